// File: rtl/button_led_mode_ctrl_if.sv
// Board-side bundle for the button/LED mode controller: raw active-low
// buttons in, registered LED drives and current mode codes out.
interface button_led_mode_ctrl_if;
  logic       BUT1;
  logic       BUT2;
  logic       LED1;
  logic       LED2;
  logic [1:0] MODE1;
  logic [1:0] MODE2;

  modport master (
    output BUT1, BUT2,
    input  LED1, LED2, MODE1, MODE2
  );

  modport slave (
    input  BUT1, BUT2,
    output LED1, LED2, MODE1, MODE2
  );
endinterface

// File: rtl/button_led_mode_ctrl.sv
// Two-button LED mode sequencer: sync + debounce + press detect per button,
// a per-LED OFF/ON/BLINK_SLOW/BLINK_FAST cycle and a shared blink prescaler.
module button_led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF_FAST = 12500000
) (
  input  logic                  CLK,
  input  logic                  RST,
  button_led_mode_ctrl_if.slave io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(BLINK_HALF_FAST) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(BLINK_HALF_FAST - 1);

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;
  localparam logic [1:0] MODE_FAST = 2'd3;

  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    db;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  logic [1:0]    mode1;
  logic [1:0]    mode2;
  logic          led1;
  logic          led2;

  logic [PW-1:0] pcnt;
  logic          fast_phase;
  logic          slow_phase;
  logic [1:0]    fast_cnt;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return (m == MODE_FAST) ? MODE_OFF : m + 2'd1;
  endfunction

  function automatic logic led_sel(input logic [1:0] m, input logic slow, input logic fast);
    case (m)
      MODE_OFF:  return 1'b0;
      MODE_ON:   return 1'b1;
      MODE_SLOW: return slow;
      default:   return fast;
    endcase
  endfunction

  assign raw = {io.BUT2, io.BUT1};

  // Synchroniser, debounce and press detect; buttons are inverted so 1 = pressed
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= ~raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]    <= s2[i];
          press[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Mode sequencing; a simultaneous press on both buttons is a global off
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode1 <= MODE_OFF;
      mode2 <= MODE_OFF;
    end else if (press == 2'b11) begin
      mode1 <= MODE_OFF;
      mode2 <= MODE_OFF;
    end else begin
      if (press[0]) mode1 <= next_mode(mode1);
      if (press[1]) mode2 <= next_mode(mode2);
    end
  end

  // Free-running blink prescaler; slow phase toggles on every 4th fast toggle
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt       <= '0;
      fast_phase <= 1'b0;
      slow_phase <= 1'b0;
      fast_cnt   <= '0;
    end else if (pcnt == P_LAST) begin
      pcnt       <= '0;
      fast_phase <= ~fast_phase;
      fast_cnt   <= fast_cnt + 2'd1;
      if (fast_cnt == 2'd3) slow_phase <= ~slow_phase;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      led1 <= 1'b0;
      led2 <= 1'b0;
    end else begin
      led1 <= led_sel(mode1, slow_phase, fast_phase);
      led2 <= led_sel(mode2, slow_phase, fast_phase);
    end
  end

  assign io.LED1  = led1;
  assign io.LED2  = led2;
  assign io.MODE1 = mode1;
  assign io.MODE2 = mode2;

endmodule

// File: tb/tb_button_led_mode_ctrl.sv
// Directed bench for button_led_mode_ctrl with short debounce and blink periods.
module tb_button_led_mode_ctrl;
  localparam int DB  = 4;
  localparam int BHF = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ec = 0;

  button_led_mode_ctrl_if bif();

  button_led_mode_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .BLINK_HALF_FAST (BHF)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (bif.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One rising edge; ec counts non-reset edges since the last reset edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) ec = 0;
    else ec++;
    #1;
  endtask

  // LED value registered at an edge, given the mode held before that edge and
  // n = number of non-reset edges before it (prescaler phase after n edges).
  function automatic int led_model(input int m, input int n);
    case (m)
      0:       return 0;
      1:       return 1;
      2:       return (n / (4 * BHF)) % 2;
      default: return (n / BHF) % 2;
    endcase
  endfunction

  task automatic press_btn(input int b, input int low_cyc, input int high_cyc);
    if (b == 1) bif.BUT1 = 1'b0; else bif.BUT2 = 1'b0;
    repeat (low_cyc) tick();
    if (b == 1) bif.BUT1 = 1'b1; else bif.BUT2 = 1'b1;
    repeat (high_cyc) tick();
  endtask

  initial begin
    int m_old;
    int m_new;
    int mb;
    bif.BUT1 = 1'b1;
    bif.BUT2 = 1'b1;

    // Test 1: reset and idle
    RST = 1'b1;
    repeat (3) tick();
    check("rst_outputs", {bif.LED1, bif.LED2, bif.MODE1, bif.MODE2}, 0);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", {bif.LED1, bif.LED2, bif.MODE1, bif.MODE2}, 0);
    end

    // Test 3: short glitches never register
    for (int r = 0; r < 5; r++) begin
      bif.BUT1 = 1'b0;
      repeat (3) tick();
      bif.BUT1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check("bounce_mode1", bif.MODE1, 0);
        check("bounce_led1", bif.LED1, 0);
      end
    end

    // Test 2: single held press, latency and no event on release
    bif.BUT1 = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("press_mode1", bif.MODE1, (i >= 7) ? 1 : 0);
      check("press_led1", bif.LED1, (i >= 8) ? 1 : 0);
    end
    bif.BUT1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("release_mode1", bif.MODE1, 1);
      check("release_led1", bif.LED1, 1);
    end

    // Test 4: BUT2 steps through all four modes with blink phases
    for (int p = 0; p < 4; p++) begin
      m_old = p;
      m_new = (p + 1) % 4;
      bif.BUT2 = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        if (i == 9) bif.BUT2 = 1'b1;
        tick();
        mb = (i >= 8) ? m_new : m_old;
        check("cycle_mode2", bif.MODE2, (i >= 7) ? m_new : m_old);
        check("cycle_led2", bif.LED2, led_model(mb, ec - 1));
      end
    end
    check("mode2_wrapped", bif.MODE2, 0);
    check("led2_off", bif.LED2, 0);

    // Test 5: simultaneous press from MODE1=1, MODE2=2 is a global off
    press_btn(2, 8, 8);
    press_btn(2, 8, 8);
    check("pre_both_mode1", bif.MODE1, 1);
    check("pre_both_mode2", bif.MODE2, 2);
    bif.BUT1 = 1'b0;
    bif.BUT2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("both_mode1", bif.MODE1, (i >= 7) ? 0 : 1);
      check("both_mode2", bif.MODE2, (i >= 7) ? 0 : 2);
      check("both_led1", bif.LED1, (i >= 8) ? 0 : 1);
      check("both_led2", bif.LED2, (i >= 8) ? 0 : led_model(2, ec - 1));
    end
    bif.BUT1 = 1'b1;
    bif.BUT2 = 1'b1;
    repeat (10) tick();

    // Test 6: reset while a button is held, then re-registration
    press_btn(1, 8, 8);
    press_btn(1, 8, 8);
    bif.BUT1 = 1'b0;
    repeat (10) tick();
    check("held_mode1", bif.MODE1, 3);
    RST = 1'b1;
    tick();
    check("midrst_outputs", {bif.LED1, bif.LED2, bif.MODE1, bif.MODE2}, 0);
    tick();
    check("midrst_outputs2", {bif.LED1, bif.LED2, bif.MODE1, bif.MODE2}, 0);
    RST = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("post_rst_mode1", bif.MODE1, (i >= 7) ? 1 : 0);
      check("post_rst_led1", bif.LED1, (i >= 8) ? 1 : 0);
      check("post_rst_mode2", bif.MODE2, 0);
    end
    bif.BUT1 = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
